// File: rtl/wca_strobe_sched_pkg.sv
// Shared constants and types for the strobe scheduler.
// Channel count, rate width, channel index and rate types.
package wca_strobe_sched_pkg;

  localparam int WCA_NCHAN = 4;
  localparam int WCA_WIDTH = 24;

  typedef logic [1:0]           chan_idx_t;
  typedef logic [WCA_WIDTH-1:0] rate_t;

endpackage

// File: rtl/wca_rr_arb4.sv
// Combinational round-robin picker over four requests.
// Picks the first request at or after ptr_i, circularly.
module wca_rr_arb4
  import wca_strobe_sched_pkg::*;
(
  input  logic [WCA_NCHAN-1:0] req_i,
  input  chan_idx_t            ptr_i,
  output logic [WCA_NCHAN-1:0] gnt_o,
  output chan_idx_t            idx_o,
  output logic                 any_o
);

  logic [WCA_NCHAN-1:0] rot;
  chan_idx_t            off;

  // rotate so ptr sits at bit 0, find lowest set bit, map back
  always_comb begin
    rot = '0;
    off = '0;
    for (int k = 0; k < WCA_NCHAN; k++) begin
      rot[k] = req_i[chan_idx_t'(ptr_i + chan_idx_t'(k))];
    end
    for (int k = WCA_NCHAN - 1; k >= 0; k--) begin
      if (rot[k]) off = chan_idx_t'(k);
    end
    any_o = |req_i;
    idx_o = any_o ? chan_idx_t'(ptr_i + off) : '0;
    gnt_o = any_o ? (WCA_NCHAN'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/wca_strobe_sched.sv
// Four-channel strobe scheduler sharing one datapath.
// Per-channel rate counters feed a round-robin grant.
module wca_strobe_sched
  import wca_strobe_sched_pkg::*;
#(
  parameter int NCHAN = WCA_NCHAN,
  parameter int WIDTH = WCA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe_in,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_rate,
  input  logic             cfg_en,
  input  logic             dp_ready,
  input  logic [NCHAN-1:0] overrun_clr,
  output logic [NCHAN-1:0] grant,
  output logic             grant_valid,
  output logic [1:0]       grant_id,
  output logic [NCHAN-1:0] pending,
  output logic [NCHAN-1:0] overrun
);

  localparam int NCH = WCA_NCHAN;

  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [NCH-1:0] grant_q, grant_d;
  chan_idx_t      gid_q, gid_d;
  chan_idx_t      rr_q, rr_d;
  rate_t          shadow_q [NCH];
  rate_t          shadow_d [NCH];
  rate_t          active_q [NCH];
  rate_t          active_d [NCH];
  rate_t          cnt_q [NCH];
  rate_t          cnt_d [NCH];

  logic [NCH-1:0] tick;
  logic [NCH-1:0] pick;
  logic [NCH-1:0] take;
  chan_idx_t      pick_idx;
  logic           pick_any;

  wca_rr_arb4 u_arb (
    .req_i (pend_q),
    .ptr_i (rr_q),
    .gnt_o (pick),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // grant issue and round-robin pointer advance
  always_comb begin
    take    = dp_ready ? pick : '0;
    grant_d = take;
    gid_d   = '0;
    rr_d    = rr_q;
    if (dp_ready && pick_any) begin
      gid_d = pick_idx;
      rr_d  = chan_idx_t'(pick_idx + 2'd1);
    end
  end

  // per-channel config, rate counter, pending and overrun
  always_comb begin
    en_d   = en_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    tick   = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      cnt_d[i]    = cnt_q[i];
      if (cfg_wr && cfg_sel == chan_idx_t'(i)) begin
        shadow_d[i] = cfg_rate;
        en_d[i]     = cfg_en;
      end
      if (!en_q[i]) begin
        cnt_d[i]    = '0;
        active_d[i] = shadow_q[i];
      end else if (strobe_in) begin
        if (cnt_q[i] == active_q[i]) begin
          cnt_d[i]    = '0;
          active_d[i] = shadow_q[i];
          tick[i]     = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (!en_q[i]) pend_d[i] = 1'b0;
      else if (tick[i]) pend_d[i] = 1'b1;
      else if (take[i]) pend_d[i] = 1'b0;
      if (tick[i] && pend_q[i] && !take[i]) ovr_d[i] = 1'b1;
      else if (overrun_clr[i]) ovr_d[i] = 1'b0;
    end
  end

  // control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
    end else begin
      en_q    <= en_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
    end
  end

  // per-channel rate and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
  assign pending     = pend_q;
  assign overrun     = ovr_q;

endmodule
